// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared encodings for the load/store unit.
// Holds the access-size codes, the FSM state type and the alignment helper
// used when the design is built with LSU_ALIGN_CHECK_EN.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  // True when the access cannot be served: a half on an odd byte, a word
  // off a word boundary, or the reserved size code.
  function automatic logic is_misaligned(input logic [1:0] addrLo, input logic [1:0] size);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addrLo[0];
      SZ_WORD: bad = (addrLo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// lsu_load_extract -- combinational lane select and sign/zero extension
// for loads. Lanes are little-endian; a halfword uses only addr[1] so the
// odd-byte bit is ignored here.
module lsu_load_extract
  import lsu_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [WORD_SIZE-1:0] word_i,
  input  logic [1:0]           addr_i,
  input  logic [1:0]           size_i,
  input  logic                 unsigned_i,
  output logic [WORD_SIZE-1:0] ext_o
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  // Pick the addressed lane(s) and widen them back to a full word.
  always_comb begin
    byteVal = 8'(word_i >> {addr_i, 3'b000});
    halfVal = 16'(word_i >> {addr_i[1], 4'b0000});
    ext_o   = word_i;
    case (size_i)
      SZ_BYTE: ext_o = unsigned_i ? {{(WORD_SIZE-8){1'b0}}, byteVal}
                                  : {{(WORD_SIZE-8){byteVal[7]}}, byteVal};
      SZ_HALF: ext_o = unsigned_i ? {{(WORD_SIZE-16){1'b0}}, halfVal}
                                  : {{(WORD_SIZE-16){halfVal[15]}}, halfVal};
      default: ext_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit -- single-outstanding load/store engine in front of a
// word-addressed RAM (combinational read, write on posedge clk).
// Word stores write directly in ACCESS; byte/half stores read in ACCESS,
// merge, and write in MERGE. Optional build macro LSU_ALIGN_CHECK_EN
// rejects misaligned or reserved-size requests with resp_err; without it
// the low address bits are ignored and size 3 behaves as a word.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [WORD_SIZE-1:0] resp_rdata,
  output logic                 resp_err,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  localparam logic [WORD_SIZE-1:0] BYTE_MASK = {{(WORD_SIZE-8){1'b0}}, 8'hFF};
  localparam logic [WORD_SIZE-1:0] HALF_MASK = {{(WORD_SIZE-16){1'b0}}, 16'hFFFF};

  lsu_state_e           state_q;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [1:0]           size_q;
  logic                 we_q;
  logic                 unsigned_q;
  logic [WORD_SIZE-1:0] merge_q;
  logic [WORD_SIZE-1:0] merge_d;
  logic                 memWe_q;
  logic                 respValid_q;
  logic                 respErr_q;
  logic [WORD_SIZE-1:0] respRdata_q;
  logic [WORD_SIZE-1:0] loadExt;
  logic [1:0]           reqSizeEff;
  logic                 reqErr;
  logic                 accept;
  logic [4:0]           laneShift;
  logic [WORD_SIZE-1:0] laneMask;
  logic [WORD_SIZE-1:0] laneData;

  assign accept     = req_valid && req_ready;
  assign reqSizeEff = (req_size == SZ_RSVD) ? SZ_WORD : req_size;

`ifdef LSU_ALIGN_CHECK_EN
  assign reqErr = is_misaligned(req_addr[1:0], req_size);
`else
  assign reqErr = 1'b0;
`endif

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = respValid_q;
  assign resp_err   = respErr_q;
  assign resp_rdata = respRdata_q;
  assign mem_we     = memWe_q;
  assign mem_addr   = ((state_q == ACCESS) || (state_q == MERGE))
                      ? {addr_q[WORD_SIZE-1:2], 2'b00} : '0;
  assign mem_wdata  = (state_q == MERGE) ? merge_q : wdata_q;

  lsu_load_extract #(
    .WORD_SIZE (WORD_SIZE)
  ) u_extract (
    .word_i     (mem_rdata),
    .addr_i     (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .ext_o      (loadExt)
  );

  // Build the read-modify-write word: old memory word with the addressed lane(s) replaced.
  always_comb begin
    laneShift = '0;
    laneMask  = '0;
    laneData  = '0;
    case (size_q)
      SZ_BYTE: begin
        laneShift = {addr_q[1:0], 3'b000};
        laneMask  = BYTE_MASK << laneShift;
        laneData  = {{(WORD_SIZE-8){1'b0}}, wdata_q[7:0]} << laneShift;
      end
      SZ_HALF: begin
        laneShift = {addr_q[1], 4'b0000};
        laneMask  = HALF_MASK << laneShift;
        laneData  = {{(WORD_SIZE-16){1'b0}}, wdata_q[15:0]} << laneShift;
      end
      default: begin
        laneMask = '0;
      end
    endcase
    merge_d = (mem_rdata & ~laneMask) | (laneData & laneMask);
  end

  // Request FSM with registered write strobe, response flags and load data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= SZ_BYTE;
      we_q        <= 1'b0;
      unsigned_q  <= 1'b0;
      merge_q     <= '0;
      memWe_q     <= 1'b0;
      respValid_q <= 1'b0;
      respErr_q   <= 1'b0;
      respRdata_q <= '0;
    end else begin
      memWe_q     <= 1'b0;
      respValid_q <= 1'b0;
      respErr_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            size_q     <= reqSizeEff;
            we_q       <= req_we;
            unsigned_q <= req_unsigned;
            if (reqErr) begin
              state_q     <= RESP;
              respValid_q <= 1'b1;
              respErr_q   <= 1'b1;
            end else begin
              state_q <= ACCESS;
              if (req_we && (reqSizeEff == SZ_WORD)) begin
                memWe_q <= 1'b1;
              end
            end
          end
        end
        ACCESS: begin
          if (!we_q) begin
            respRdata_q <= loadExt;
            respValid_q <= 1'b1;
            state_q     <= RESP;
          end else if (size_q == SZ_WORD) begin
            respValid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            merge_q <= merge_d;
            memWe_q <= 1'b1;
            state_q <= MERGE;
          end
        end
        MERGE: begin
          respValid_q <= 1'b1;
          state_q     <= RESP;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
